// File: rtl/calc_dp_if.sv
// Control-word and result bundle between the calculator control unit and its datapath.
// The master side drives operands and the control word; the slave side returns results.
interface calc_dp_if #(
  parameter int W = 4
);
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         we;
  logic [1:0]   wa;
  logic [1:0]   s1;
  logic         rea;
  logic [1:0]   raa;
  logic         reb;
  logic [1:0]   rab;
  logic [1:0]   c;
  logic         s2;
  logic         done_calc;
  logic [W-1:0] out;
  logic         carry;
  logic         zero;
  logic         out_valid;

  modport master (
    output in1, in2, we, wa, s1, rea, raa, reb, rab, c, s2, done_calc,
    input  out, carry, zero, out_valid
  );

  modport slave (
    input  in1, in2, we, wa, s1, rea, raa, reb, rab, c, s2, done_calc,
    output out, carry, zero, out_valid
  );
endinterface

// File: rtl/calc_dp.sv
// Calculator datapath: 4-entry register file, write-data mux, 2-operand ALU,
// registered result/flag stage and a rising-edge completion pulse.
module calc_dp #(
  parameter int W = 4
) (
  input logic      clk,
  input logic      rst,
  calc_dp_if.slave bus
);

  logic [W-1:0] rf [4];
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W:0]   alu;
  logic [W-1:0] wdata;
  logic         done_q;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    a = '0;
    b = '0;
    if (bus.rea) a = rf[bus.raa];
    if (bus.reb) b = rf[bus.rab];
  end

  // Bit W is the carry for add and the borrow (A < B) for subtract.
  always_comb begin
    alu = '0;
    case (bus.c)
      2'b00:   alu = {1'b0, a} + {1'b0, b};
      2'b01:   alu = {1'b0, a} - {1'b0, b};
      2'b10:   alu = {1'b0, a & b};
      default: alu = {1'b0, a ^ b};
    endcase
  end

  always_comb begin
    wdata = '0;
    case (bus.s1)
      2'b11:   wdata = bus.in1;
      2'b10:   wdata = bus.in2;
      2'b00:   wdata = alu[W-1:0];
      default: wdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (bus.we && (bus.wa != 2'd0)) begin
      rf[bus.wa] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out   <= '0;
      bus.carry <= 1'b0;
      bus.zero  <= 1'b0;
    end else if (bus.s2) begin
      bus.out   <= alu[W-1:0];
      bus.carry <= alu[W];
      bus.zero  <= (alu[W-1:0] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q        <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      done_q        <= bus.done_calc;
      bus.out_valid <= bus.done_calc & ~done_q;
    end
  end

endmodule
